mesi_isc_broad_cntl: RTL and testbench

Broadcast controller of the MESI intersection controller. Sits directly downstream of the broadcast FIFO (a `mesi_isc_basic_fifo` instance written by the bus-request FIFO controller). It pops one broadcast entry at a time and drives a snoop command on the coherence bus to every non-initiating CPU. It collects their acks, then grants the initiating CPU with an enable command before accepting the next entry.

---
 rtl/mesi_isc_broad_cntl.sv | 114 +++++++++++
 tb/tb_mesi_isc_broad_cntl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mesi_isc_broad_cntl.sv
// Broadcast controller: pops one broadcast entry at a time, snoops every
// non-initiating CPU, collects their acks, then enables the initiator.
module mesi_isc_broad_cntl #(
  parameter int CBUS_CMD_WIDTH   = 3,
  parameter int ADDR_WIDTH       = 32,
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH   = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          broad_fifo_status_empty_i,
  input  logic [ADDR_WIDTH-1:0]         broad_addr_i,
  input  logic [BROAD_TYPE_WIDTH-1:0]   broad_type_i,
  input  logic [1:0]                    broad_cpu_id_i,
  input  logic [BROAD_ID_WIDTH-1:0]     broad_id_i,
  input  logic [3:0]                    cbus_ack_array_i,
  output logic                          broad_fifo_rd_o,
  output logic [ADDR_WIDTH-1:0]         cbus_addr_o,
  output logic [4*CBUS_CMD_WIDTH-1:0]   cbus_cmd_array_o,
  output logic [BROAD_ID_WIDTH-1:0]     broad_id_o,
  output logic                          busy_o
);

  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_WR_SNOOP = CBUS_CMD_WIDTH'(1);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_RD_SNOOP = CBUS_CMD_WIDTH'(2);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_WR    = CBUS_CMD_WIDTH'(3);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_RD    = CBUS_CMD_WIDTH'(4);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    SNOOP,
    ENABLE
  } state_t;

  state_t                        state, state_next;
  logic [3:0]                    pending, pending_next;
  logic [ADDR_WIDTH-1:0]         addr_q;
  logic [BROAD_TYPE_WIDTH-1:0]   type_q, type_cur;
  logic [1:0]                    cpu_q, cpu_cur;
  logic [BROAD_ID_WIDTH-1:0]     id_q;
  logic [4*CBUS_CMD_WIDTH-1:0]   cmd_q, cmd_next;
  logic                          is_wr, is_rd;

  // In LATCH the entry is still on the FIFO outputs, so decode from there.
  always_comb begin
    type_cur     = (state == LATCH) ? broad_type_i : type_q;
    cpu_cur      = (state == LATCH) ? broad_cpu_id_i : cpu_q;
    is_wr        = (type_cur == BROAD_TYPE_WIDTH'(1));
    is_rd        = (type_cur == BROAD_TYPE_WIDTH'(2));
    state_next   = state;
    pending_next = pending;
    case (state)
      IDLE:   if (!broad_fifo_status_empty_i) state_next = FETCH;
      FETCH:  state_next = LATCH;
      LATCH: begin
        if (is_wr || is_rd) begin
          pending_next = 4'b1111 & ~(4'b0001 << cpu_cur);
          state_next   = SNOOP;
        end else begin
          pending_next = 4'b0000;
          state_next   = IDLE;
        end
      end
      SNOOP: begin
        pending_next = pending & ~cbus_ack_array_i;
        if (pending_next == 4'b0000) state_next = ENABLE;
      end
      ENABLE: if (cbus_ack_array_i[cpu_cur]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Commands are derived from the next state so they are registered outputs.
  always_comb begin
    cmd_next = '0;
    for (int i = 0; i < 4; i++) begin
      if (state_next == SNOOP && pending_next[i])
        cmd_next[i*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = is_wr ? CMD_WR_SNOOP : CMD_RD_SNOOP;
      else if (state_next == ENABLE && cpu_cur == 2'(i))
        cmd_next[i*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = is_wr ? CMD_EN_WR : CMD_EN_RD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pending <= 4'b0000;
      cmd_q   <= '0;
      addr_q  <= '0;
      type_q  <= '0;
      cpu_q   <= 2'b00;
      id_q    <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      cmd_q   <= cmd_next;
      if (state == LATCH) begin
        addr_q <= broad_addr_i;
        type_q <= broad_type_i;
        cpu_q  <= broad_cpu_id_i;
        id_q   <= broad_id_i;
      end
    end
  end

  assign broad_fifo_rd_o  = (state == FETCH);
  assign busy_o           = (state != IDLE);
  assign cbus_cmd_array_o = cmd_q;
  assign cbus_addr_o      = addr_q;
  assign broad_id_o       = id_q;

endmodule

// File: tb/tb_mesi_isc_broad_cntl.sv
// Directed bench for mesi_isc_broad_cntl: a small FIFO model feeds entries,
// a cycle table drives acks and holds the hand-computed expected outputs.
module tb_mesi_isc_broad_cntl;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  btype;
    logic [1:0]  cpu;
    logic [6:0]  id;
  } entry_t;

  typedef struct {
    logic [3:0]  ack;
    logic        expRd;
    logic        expBusy;
    logic [11:0] expCmd;
    logic [31:0] expAddr;
    logic [6:0]  expId;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        fifoEmpty;
  logic [3:0]  cbusAck;
  logic        rdStrobe;
  logic [31:0] cbusAddr;
  logic [11:0] cbusCmd;
  logic [6:0]  broadId;
  logic        busy;

  entry_t      fifoMem [8];
  entry_t      fifoData;
  int          wrPtr;
  int          rdPtr;
  vec_t        vecQ [$];
  int          testsRun;
  int          testsFailed;

  mesi_isc_broad_cntl dut (
    .clk                       (clk),
    .rst                       (rst),
    .broad_fifo_status_empty_i (fifoEmpty),
    .broad_addr_i              (fifoData.addr),
    .broad_type_i              (fifoData.btype),
    .broad_cpu_id_i            (fifoData.cpu),
    .broad_id_i                (fifoData.id),
    .cbus_ack_array_i          (cbusAck),
    .broad_fifo_rd_o           (rdStrobe),
    .cbus_addr_o               (cbusAddr),
    .cbus_cmd_array_o          (cbusCmd),
    .broad_id_o                (broadId),
    .busy_o                    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model pops mid-cycle while the read strobe is stable
  assign fifoEmpty = (wrPtr == rdPtr);
  initial begin
    rdPtr    = 0;
    fifoData = '0;
  end
  always @(negedge clk) begin
    if (rdStrobe && !fifoEmpty) begin
      fifoData <= fifoMem[rdPtr];
      rdPtr    <= rdPtr + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] ack);
    cbusAck = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic pushEntry(input logic [31:0] a, input logic [1:0] t, input logic [1:0] c, input logic [6:0] i);
    entry_t e;
    e.addr  = a;
    e.btype = t;
    e.cpu   = c;
    e.id    = i;
    fifoMem[wrPtr] = e;
    wrPtr = wrPtr + 1;
  endtask

  task automatic addVec(input logic [3:0] a, input logic r, input logic b, input logic [11:0] c,
                        input logic [31:0] ad, input logic [6:0] i);
    vec_t v;
    v.ack = a; v.expRd = r; v.expBusy = b; v.expCmd = c; v.expAddr = ad; v.expId = i;
    vecQ.push_back(v);
  endtask

  task automatic checkAll(input string tag, input logic r, input logic b, input logic [11:0] c,
                          input logic [31:0] ad, input logic [6:0] i);
    checkOutput({tag, " rd"},   32'(rdStrobe), 32'(r));
    checkOutput({tag, " busy"}, 32'(busy),     32'(b));
    checkOutput({tag, " cmd"},  32'(cbusCmd),  32'(c));
    checkOutput({tag, " addr"}, cbusAddr,      ad);
    checkOutput({tag, " id"},   32'(broadId),  32'(i));
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    wrPtr       = 0;
    rst         = 1'b0;
    cbusAck     = 4'b0000;

    // Four queued entries: write, read, illegal type, write from CPU 3
    pushEntry(32'h1000, 2'b01, 2'd2, 7'd5);
    pushEntry(32'h2000, 2'b10, 2'd0, 7'd7);
    pushEntry(32'h3000, 2'b00, 2'd1, 7'd9);
    pushEntry(32'h4000, 2'b01, 2'd3, 7'h2A);

    // Entry 1: write, initiator 2, spurious acks from CPU 2 and CPU 1
    addVec(4'b0000, 1, 1, 12'h000, 32'h0000, 7'd0);
    addVec(4'b0000, 0, 1, 12'h000, 32'h0000, 7'd0);
    addVec(4'b0000, 0, 1, 12'h209, 32'h1000, 7'd5);
    addVec(4'b0100, 0, 1, 12'h209, 32'h1000, 7'd5);
    addVec(4'b0001, 0, 1, 12'h208, 32'h1000, 7'd5);
    addVec(4'b0010, 0, 1, 12'h200, 32'h1000, 7'd5);
    addVec(4'b1000, 0, 1, 12'h0C0, 32'h1000, 7'd5);
    addVec(4'b0010, 0, 1, 12'h0C0, 32'h1000, 7'd5);
    addVec(4'b0100, 0, 0, 12'h000, 32'h1000, 7'd5);
    // Entry 2: read, initiator 0, simultaneous final acks
    addVec(4'b0000, 1, 1, 12'h000, 32'h1000, 7'd5);
    addVec(4'b0000, 0, 1, 12'h000, 32'h1000, 7'd5);
    addVec(4'b0000, 0, 1, 12'h490, 32'h2000, 7'd7);
    addVec(4'b0001, 0, 1, 12'h490, 32'h2000, 7'd7);
    addVec(4'b1110, 0, 1, 12'h004, 32'h2000, 7'd7);
    addVec(4'b0010, 0, 1, 12'h004, 32'h2000, 7'd7);
    addVec(4'b0001, 0, 0, 12'h000, 32'h2000, 7'd7);
    // Entry 3: illegal type is dropped right after LATCH
    addVec(4'b0000, 1, 1, 12'h000, 32'h2000, 7'd7);
    addVec(4'b0000, 0, 1, 12'h000, 32'h2000, 7'd7);
    addVec(4'b0000, 0, 0, 12'h000, 32'h3000, 7'd9);
    // Entry 4: write, initiator 3, ack held high from SNOOP into ENABLE
    addVec(4'b0000, 1, 1, 12'h000, 32'h3000, 7'd9);
    addVec(4'b0000, 0, 1, 12'h000, 32'h3000, 7'd9);
    addVec(4'b0000, 0, 1, 12'h049, 32'h4000, 7'h2A);
    addVec(4'b1111, 0, 1, 12'h600, 32'h4000, 7'h2A);
    addVec(4'b0010, 0, 1, 12'h600, 32'h4000, 7'h2A);
    addVec(4'b1000, 0, 0, 12'h000, 32'h4000, 7'h2A);
    addVec(4'b0000, 0, 0, 12'h000, 32'h4000, 7'h2A);
    addVec(4'b0000, 0, 0, 12'h000, 32'h4000, 7'h2A);

    repeat (2) @(posedge clk);
    #1;
    checkAll("reset", 1'b0, 1'b0, 12'h000, 32'h0, 7'd0);
    #2 rst = 1'b1;

    for (int v = 0; v < vecQ.size(); v++) begin
      applyStimulus(vecQ[v].ack);
      checkAll($sformatf("vec%0d", v), vecQ[v].expRd, vecQ[v].expBusy, vecQ[v].expCmd,
               vecQ[v].expAddr, vecQ[v].expId);
    end
    checkOutput("rd pulses after table", 32'(rdPtr), 32'd4);

    // Asynchronous reset in the middle of a SNOOP phase
    pushEntry(32'h5000, 2'b10, 2'd1, 7'd3);
    applyStimulus(4'b0000);
    checkOutput("abort fetch rd", 32'(rdStrobe), 32'd1);
    applyStimulus(4'b0000);
    applyStimulus(4'b0000);
    checkAll("abort snoop", 1'b0, 1'b1, 12'h482, 32'h5000, 7'd3);
    #3 rst = 1'b0;
    #1;
    checkAll("abort in reset", 1'b0, 1'b0, 12'h000, 32'h0, 7'd0);
    #3 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b0000);
      checkOutput($sformatf("post reset busy%0d", c), 32'(busy), 32'd0);
      checkOutput($sformatf("post reset rd%0d", c), 32'(rdStrobe), 32'd0);
      checkOutput($sformatf("post reset cmd%0d", c), 32'(cbusCmd), 32'd0);
    end
    checkOutput("rd pulses total", 32'(rdPtr), 32'd5);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
